// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NREQ
// byte requesters. A grant lasts for one packet or BURST_MAX bytes, each byte
// is launched, acked via tx_busy, and waited out; a watchdog on the ack flags
// a dead transmitter (sticky ack_err) and releases the grant.
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int BYTESIZES   = 8,
  parameter int BURST_MAX   = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*BYTESIZES-1:0]   req_data,
  input  logic [NREQ-1:0]             req_last,
  output logic [NREQ-1:0]             req_ready,
  output logic                        tx_start,
  output logic [BYTESIZES-1:0]        tx_data,
  input  logic                        tx_busy,
  output logic                        grant_valid,
  output logic [$clog2(NREQ)-1:0]     grant_id,
  output logic                        ack_err
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BURST_MAX + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  state_t                r_state, w_state;
  logic [IW-1:0]         r_rr_ptr, w_rr_ptr;
  logic [CW-1:0]         r_byte_cnt, w_byte_cnt;
  logic                  r_last_q, w_last_q;
  logic [TW-1:0]         r_timer, w_timer;
  logic                  r_tx_start, w_tx_start;
  logic [BYTESIZES-1:0]  r_tx_data, w_tx_data;
  logic [NREQ-1:0]       r_req_ready, w_req_ready;
  logic                  r_grant_valid, w_grant_valid;
  logic [IW-1:0]         r_grant_id, w_grant_id;
  logic                  r_ack_err, w_ack_err;

  logic                  w_found;
  logic [IW-1:0]         w_pick;
  logic [IW-1:0]         w_ptr_after;

  // Round-robin search: first pending requester starting at rr_ptr, wrapping.
  always_comb begin
    logic [IW-1:0] cand;
    w_found = 1'b0;
    w_pick  = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((r_rr_ptr + k) % NREQ);
      if (!w_found && req_valid[cand]) begin
        w_found = 1'b1;
        w_pick  = cand;
      end
    end
  end

  // Pointer value after releasing the current owner.
  always_comb begin
    w_ptr_after = (r_grant_id == IW'(NREQ - 1)) ? '0 : r_grant_id + 1'b1;
  end

  // Next-state and registered-output logic.
  // The ack timer is cleared on the launch edge, so reaching ACK_TIMEOUT-1
  // without busy means ACK_TIMEOUT edges have passed since launch. A timeout
  // release advances rr_ptr like a normal release so a dead requester slot
  // does not monopolise retries.
  always_comb begin
    w_state       = r_state;
    w_rr_ptr      = r_rr_ptr;
    w_byte_cnt    = r_byte_cnt;
    w_last_q      = r_last_q;
    w_timer       = r_timer;
    w_tx_start    = 1'b0;
    w_tx_data     = r_tx_data;
    w_req_ready   = '0;
    w_grant_valid = r_grant_valid;
    w_grant_id    = r_grant_id;
    w_ack_err     = r_ack_err;
    case (r_state)
      S_IDLE: begin
        if (!tx_busy && w_found) begin
          w_state       = S_WAIT_ACK;
          w_grant_id    = w_pick;
          w_grant_valid = 1'b1;
          w_tx_data     = req_data[w_pick*BYTESIZES +: BYTESIZES];
          w_tx_start    = 1'b1;
          w_req_ready   = NREQ'(1) << w_pick;
          w_byte_cnt    = CW'(1);
          w_last_q      = req_last[w_pick];
          w_timer       = '0;
        end
      end
      S_WAIT_ACK: begin
        if (tx_busy) begin
          w_state = S_WAIT_DONE;
          w_timer = '0;
        end else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
          w_ack_err     = 1'b1;
          w_grant_valid = 1'b0;
          w_byte_cnt    = '0;
          w_rr_ptr      = w_ptr_after;
          w_timer       = '0;
          w_state       = S_IDLE;
        end else begin
          w_timer = r_timer + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (!r_last_q && (r_byte_cnt < CW'(BURST_MAX)) && req_valid[r_grant_id]) begin
            w_state     = S_WAIT_ACK;
            w_tx_data   = req_data[r_grant_id*BYTESIZES +: BYTESIZES];
            w_tx_start  = 1'b1;
            w_req_ready = NREQ'(1) << r_grant_id;
            w_byte_cnt  = r_byte_cnt + 1'b1;
            w_last_q    = req_last[r_grant_id];
            w_timer     = '0;
          end else begin
            w_state       = S_IDLE;
            w_grant_valid = 1'b0;
            w_rr_ptr      = w_ptr_after;
            w_byte_cnt    = '0;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_byte_cnt    <= '0;
      r_last_q      <= 1'b0;
      r_timer       <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_req_ready   <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_ack_err     <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_rr_ptr      <= w_rr_ptr;
      r_byte_cnt    <= w_byte_cnt;
      r_last_q      <= w_last_q;
      r_timer       <= w_timer;
      r_tx_start    <= w_tx_start;
      r_tx_data     <= w_tx_data;
      r_req_ready   <= w_req_ready;
      r_grant_valid <= w_grant_valid;
      r_grant_id    <= w_grant_id;
      r_ack_err     <= w_ack_err;
    end
  end

  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign req_ready   = r_req_ready;
  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;
  assign ack_err     = r_ack_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: table of single-byte arbitration cases,
// hand-written burst/packet/timeout/reset sequences, and randomized packet
// traffic compared against a transaction-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int BW   = 8;
  localparam int BURST = 4;
  localparam int TMO  = 64;
  localparam int IW   = 2;
  localparam int QD   = 256;
  localparam int OD   = 1024;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NREQ-1:0]    req_valid, req_last, req_ready;
  logic [NREQ*BW-1:0] req_data;
  logic               tx_start, tx_busy, grant_valid, ack_err;
  logic [BW-1:0]      tx_data;
  logic [IW-1:0]      grant_id;

  int errors = 0;
  int checks = 0;

  // Input sources: direct table drive or queue-backed requesters.
  logic               use_q = 1'b0;
  logic [NREQ-1:0]    t_valid = '0, t_last = '0;
  logic [NREQ*BW-1:0] t_data = '0;
  logic [NREQ-1:0]    q_valid = '0, q_last = '0;
  logic [NREQ*BW-1:0] q_data = '0;
  assign req_valid = use_q ? q_valid : t_valid;
  assign req_last  = use_q ? q_last  : t_last;
  assign req_data  = use_q ? q_data  : t_data;

  logic auto_en = 1'b0;
  logic busy_auto = 1'b0;
  logic busy_man = 1'b0;
  assign tx_busy = auto_en ? busy_auto : busy_man;

  uart_tx_arbiter #(
    .NREQ(NREQ), .BYTESIZES(BW), .BURST_MAX(BURST), .ACK_TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_valid(grant_valid), .grant_id(grant_id), .ack_err(ack_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Requester byte queues: {last, data}.
  logic [8:0] mem [NREQ][QD];
  int head [NREQ];
  int tail [NREQ];
  int mstart [NREQ];

  always @(negedge clock) begin : drv
    int h;
    for (int i = 0; i < NREQ; i++) begin
      h = head[i];
      if (use_q && req_ready[i] && h != tail[i]) h = h + 1;
      head[i] <= h;
      q_valid[i] <= (h != tail[i]);
      q_data[i*BW +: BW] <= mem[i][h % QD][7:0];
      q_last[i] <= mem[i][h % QD][8];
    end
  end

  // Transmitter model: random ack delay, random frame length.
  int rs = 0, dly = 0, len = 0;
  always @(negedge clock) begin
    if (!auto_en) begin
      rs <= 0;
      busy_auto <= 1'b0;
    end else begin
      case (rs)
        0: if (tx_start) begin dly <= int'($urandom_range(0, 4)); rs <= 1; end
        1: if (dly == 0) begin busy_auto <= 1'b1; len <= int'($urandom_range(0, 5)); rs <= 2; end
           else dly <= dly - 1;
        2: if (len == 0) begin busy_auto <= 1'b0; rs <= 0; end
           else len <= len - 1;
        default: rs <= 0;
      endcase
    end
  end

  // Launch monitor.
  int obs_n = 0;
  logic [IW-1:0]   obs_id   [OD];
  logic [BW-1:0]   obs_data [OD];
  logic [NREQ-1:0] obs_rdy  [OD];
  logic            obs_gv   [OD];
  int              obs_cyc  [OD];
  always @(negedge clock) begin
    if (tx_start) begin
      obs_id[obs_n % OD]   <= grant_id;
      obs_data[obs_n % OD] <= tx_data;
      obs_rdy[obs_n % OD]  <= req_ready;
      obs_gv[obs_n % OD]   <= grant_valid;
      obs_cyc[obs_n % OD]  <= cyc;
      obs_n <= obs_n + 1;
    end
  end

  int exp_id [512];
  logic [7:0] exp_data [512];
  int exp_n = 0;

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [7:0]      base;
    logic [IW-1:0]   exp_id;
    logic [NREQ-1:0] exp_rdy;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic last);
    mem[i][tail[i] % QD] = {last, d};
    tail[i] = tail[i] + 1;
  endtask

  task automatic add_exp(input int id, input logic [7:0] d);
    exp_id[exp_n] = id;
    exp_data[exp_n] = d;
    exp_n++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_launch(input int base, input string tag);
    int n = 0;
    while (obs_n == base && n < 30) begin @(negedge clock); n++; end
    chk({tag, "_launch"}, 64'(obs_n > base), 64'd1);
  endtask

  // Compare recorded launches from index base against the expected list.
  task automatic run_expect(input int base, input string tag);
    int n = 0;
    logic [NREQ-1:0] r;
    while ((obs_n - base) < exp_n && n < 5000) begin @(negedge clock); n++; end
    chk({tag, "_count"}, 64'(obs_n - base >= exp_n), 64'd1);
    for (int i = 0; i < exp_n; i++) begin
      r = '0;
      r[exp_id[i]] = 1'b1;
      chk($sformatf("%s[%0d].id", tag, i),   64'(obs_id[(base + i) % OD]), 64'(exp_id[i]));
      chk($sformatf("%s[%0d].data", tag, i), 64'(obs_data[(base + i) % OD]), 64'(exp_data[i]));
      chk($sformatf("%s[%0d].rdy", tag, i),  64'(obs_rdy[(base + i) % OD]), 64'(r));
      chk($sformatf("%s[%0d].gv", tag, i),   64'(obs_gv[(base + i) % OD]), 64'd1);
    end
    n = 0;
    while (grant_valid && n < 200) begin @(negedge clock); n++; end
    repeat (10) @(negedge clock);
    chk({tag, "_released"}, 64'(grant_valid), 64'd0);
    chk({tag, "_no_extra"}, 64'(obs_n - base), 64'(exp_n));
  endtask

  // Transaction-level reference: round-robin over requester queues, a grant
  // drains bytes until packet end, BURST bytes, or the queue runs dry.
  task automatic build_model();
    int p [NREQ];
    int ptr, g, cnt, c;
    bit done, stop;
    exp_n = 0;
    ptr = 0;
    done = 1'b0;
    for (int i = 0; i < NREQ; i++) p[i] = mstart[i];
    while (!done) begin
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        c = (ptr + k) % NREQ;
        if (g < 0 && p[c] != tail[c]) g = c;
      end
      if (g < 0) begin
        done = 1'b1;
      end else begin
        cnt = 0;
        stop = 1'b0;
        while (!stop) begin
          add_exp(g, mem[g][p[g] % QD][7:0]);
          stop = mem[g][p[g] % QD][8];
          p[g]++;
          cnt++;
          if (cnt >= BURST || p[g] == tail[g]) stop = 1'b1;
        end
        ptr = (g + 1) % NREQ;
      end
    end
  endtask

  initial begin
    int base, c0, n;
    logic [7:0] ed;

    for (int i = 0; i < NREQ; i++) tail[i] = 0;

    // Reset values.
    repeat (2) @(negedge clock);
    chk("rst_tx_start", 64'(tx_start), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_grant_valid", 64'(grant_valid), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_ack_err", 64'(ack_err), 64'd0);
    reset = 1'b0;

    // Single-byte arbitration table; rr_ptr carries across entries.
    tbl[0]  = '{4'b0100, 8'hA3, 2'd2, 4'b0100};
    tbl[1]  = '{4'b1111, 8'h10, 2'd3, 4'b1000};
    tbl[2]  = '{4'b1111, 8'h20, 2'd0, 4'b0001};
    tbl[3]  = '{4'b0001, 8'h5C, 2'd0, 4'b0001};
    tbl[4]  = '{4'b1001, 8'h31, 2'd3, 4'b1000};
    tbl[5]  = '{4'b0110, 8'hFE, 2'd1, 4'b0010};
    tbl[6]  = '{4'b0011, 8'h77, 2'd0, 4'b0001};
    tbl[7]  = '{4'b1110, 8'h08, 2'd1, 4'b0010};
    tbl[8]  = '{4'b1000, 8'hC0, 2'd3, 4'b1000};
    tbl[9]  = '{4'b0010, 8'h44, 2'd1, 4'b0010};
    tbl[10] = '{4'b1111, 8'h90, 2'd2, 4'b0100};
    tbl[11] = '{4'b1111, 8'h91, 2'd3, 4'b1000};
    tbl[12] = '{4'b1111, 8'h92, 2'd0, 4'b0001};
    tbl[13] = '{4'b1111, 8'h93, 2'd1, 4'b0010};
    for (int e = 0; e < 14; e++) begin
      @(negedge clock);
      t_valid = tbl[e].valid;
      t_last  = '1;
      for (int i = 0; i < NREQ; i++) t_data[i*BW +: BW] = tbl[e].base + 8'(i);
      ed = tbl[e].base + 8'(tbl[e].exp_id);
      @(negedge clock);
      chk($sformatf("tbl%0d_start", e), 64'(tx_start), 64'd1);
      chk($sformatf("tbl%0d_ready", e), 64'(req_ready), 64'(tbl[e].exp_rdy));
      chk($sformatf("tbl%0d_id", e), 64'(grant_id), 64'(tbl[e].exp_id));
      chk($sformatf("tbl%0d_data", e), 64'(tx_data), 64'(ed));
      chk($sformatf("tbl%0d_gv", e), 64'(grant_valid), 64'd1);
      t_valid = '0;
      @(negedge clock);
      chk($sformatf("tbl%0d_pulse", e), 64'({tx_start, req_ready}), 64'd0);
      busy_man = 1'b1;
      @(negedge clock);
      @(negedge clock);
      busy_man = 1'b0;
      @(negedge clock);
      chk($sformatf("tbl%0d_release", e), 64'(grant_valid), 64'd0);
      chk($sformatf("tbl%0d_hold", e), 64'(tx_data), 64'(ed));
    end

    // Burst cap: 6-byte packet from requester 1 split 4 + 2 around requester 2.
    do_reset();
    use_q = 1'b1;
    auto_en = 1'b1;
    base = obs_n;
    for (int b = 0; b < 6; b++) push(1, 8'h10 + 8'(b), b == 5);
    push(2, 8'h20, 1'b1);
    exp_n = 0;
    for (int b = 0; b < 4; b++) add_exp(1, 8'h10 + 8'(b));
    add_exp(2, 8'h20);
    add_exp(1, 8'h14);
    add_exp(1, 8'h15);
    run_expect(base, "burst");

    // Packet end after 2 bytes hands over to requester 3.
    do_reset();
    base = obs_n;
    push(0, 8'h30, 1'b0);
    push(0, 8'h31, 1'b1);
    push(0, 8'h32, 1'b1);
    push(3, 8'h40, 1'b1);
    exp_n = 0;
    add_exp(0, 8'h30);
    add_exp(0, 8'h31);
    add_exp(3, 8'h40);
    add_exp(0, 8'h32);
    run_expect(base, "pkt_end");

    // Randomized packet traffic against the model.
    do_reset();
    base = obs_n;
    for (int i = 0; i < NREQ; i++) begin
      mstart[i] = tail[i];
      n = int'($urandom_range(0, 4));
      for (int p = 0; p < n; p++) begin
        c0 = int'($urandom_range(1, 7));
        for (int b = 0; b < c0; b++) push(i, 8'($urandom), b == c0 - 1);
      end
    end
    build_model();
    run_expect(base, "rand");

    // Ack watchdog: transmitter never goes busy.
    do_reset();
    auto_en = 1'b0;
    busy_man = 1'b0;
    base = obs_n;
    push(2, 8'h3C, 1'b1);
    wait_launch(base, "tmo");
    c0 = obs_cyc[base % OD];
    n = 0;
    while (!ack_err && n < 200) begin @(negedge clock); n++; end
    chk("ack_err_set", 64'(ack_err), 64'd1);
    chk("ack_latency", 64'(cyc - c0), 64'(TMO));
    chk("tmo_release", 64'(grant_valid), 64'd0);
    auto_en = 1'b1;
    base = obs_n;
    push(2, 8'h5A, 1'b1);
    exp_n = 0;
    add_exp(2, 8'h5A);
    run_expect(base, "post_tmo");
    chk("ack_err_sticky", 64'(ack_err), 64'd1);

    // Reset while the transmitter is mid-frame.
    auto_en = 1'b0;
    busy_man = 1'b0;
    base = obs_n;
    push(0, 8'h11, 1'b1);
    wait_launch(base, "mid");
    busy_man = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    push(0, 8'h22, 1'b1);
    push(1, 8'h33, 1'b1);
    @(negedge clock);
    chk("mrst_tx_start", 64'(tx_start), 64'd0);
    chk("mrst_tx_data", 64'(tx_data), 64'd0);
    chk("mrst_req_ready", 64'(req_ready), 64'd0);
    chk("mrst_grant_valid", 64'(grant_valid), 64'd0);
    chk("mrst_grant_id", 64'(grant_id), 64'd0);
    chk("mrst_ack_err", 64'(ack_err), 64'd0);
    reset = 1'b0;
    base = obs_n;
    repeat (6) @(negedge clock);
    chk("no_start_while_busy", 64'(obs_n - base), 64'd0);
    exp_n = 0;
    add_exp(0, 8'h22);
    add_exp(1, 8'h33);
    auto_en = 1'b1;
    run_expect(base, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
